one_for_consecutive_ones: RTL and testbench

- Serial "group of ones" counter.
- Samples a 1-bit input stream once per clock and counts the runs of consecutive 1s.
- Each maximal run of 1s adds exactly one to the count, regardless of the run's length.
- Used as a simple event/burst counter on a serial data line.

---
 rtl/one_for_consecutive_ones.sv | 33 +++
 tb/tb_one_for_consecutive_ones.sv | 132 +++++++++++++
 2 files changed

// File: rtl/one_for_consecutive_ones.sv
// Counts maximal runs of 1s on a serial line; count updates on the edge sampling a run's first 1.
// No backpressure: the input is free-running and the count saturates at all-ones instead of wrapping.
module one_for_consecutive_ones #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] count,
    input  logic             clk,
    input  logic             rst,
    input  logic             din
);

    logic             prev_din;
    logic [WIDTH-1:0] cnt;
    logic             run_start;

    // prev_din clears on reset so a 1 sampled right after reset starts a run
    assign run_start = din && !prev_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            prev_din <= 1'b0;
        end else begin
            prev_din <= din;
            if (run_start && (cnt != {WIDTH{1'b1}})) begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

    assign count = cnt;

endmodule

// File: tb/tb_one_for_consecutive_ones.sv
// Scoreboard bench: stimulus pushes expected counts, monitor pops and compares after each edge.
module tb_one_for_consecutive_ones;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic [7:0] count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    one_for_consecutive_ones #(.WIDTH(8)) dut (
        .count (count),
        .clk   (clk),
        .rst   (rst),
        .din   (din)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the falling edge; the expected value applies after the next rising edge.
    task automatic step(input logic r, input logic d, input logic [7:0] e, input string tag);
        exp_t item;
        @(negedge clk);
        #1;
        rst = r;
        din = d;
        item.exp = e;
        item.tag = tag;
        sb.push_back(item);
    endtask

    // Monitor: one output sample per rising edge while expectations are pending.
    initial begin
        exp_t item;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                item = sb.pop_front();
                checks++;
                if (count !== item.exp) begin
                    errors++;
                    $display("FAIL %s: count=%0d expected=%0d", item.tag, count, item.exp);
                end
            end
        end
    end

    int t3_din[35] = '{1,1,1,1, 0,0, 1, 0, 1, 0,0, 1,1, 0, 1,1, 0, 1, 0, 1, 0,0,
                       1, 0, 1, 0,0, 1,1, 0, 1,1, 0, 1, 0};
    int t3_exp[35] = '{1,1,1,1, 1,1, 2, 2, 3, 3,3, 4,4, 4, 5,5, 5, 6, 6, 7, 7,7,
                       8, 8, 9, 9,9, 10,10, 10, 11,11, 11, 12, 12};

    initial begin
        // Test 1: reset with din=1, then release with din=0 held
        step(1'b1, 1'b1, 8'd0, "reset_din1_a");
        step(1'b1, 1'b1, 8'd0, "reset_din1_b");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, "release_din0");

        // Test 2: one long run then zeros
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'd1, "long_run");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'd1, "long_run_tail");

        // Test 3: mixed runs, each bit held two cycles
        step(1'b1, 1'b0, 8'd0, "t3_reset");
        for (int i = 0; i < 35; i++) begin
            step(1'b0, t3_din[i][0], t3_exp[i][7:0], "mixed_runs");
            step(1'b0, t3_din[i][0], t3_exp[i][7:0], "mixed_runs");
        end

        // Test 4: alternating 1/0, ten ones
        step(1'b1, 1'b0, 8'd0, "t4_reset");
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 8'(i), "alternate_one");
            step(1'b0, 1'b0, 8'(i), "alternate_zero");
        end

        // Test 5: 260 isolated pulses, saturates at 255
        step(1'b1, 1'b0, 8'd0, "t5_reset");
        for (int i = 1; i <= 260; i++) begin
            step(1'b0, 1'b1, (i > 255) ? 8'd255 : 8'(i), "saturate_one");
            step(1'b0, 1'b0, (i > 255) ? 8'd255 : 8'(i), "saturate_zero");
        end

        // Test 6: reset in the middle of a run
        step(1'b1, 1'b0, 8'd0, "t6_reset");
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 8'(i), "t6_pulse");
            step(1'b0, 1'b0, 8'(i), "t6_gap");
        end
        step(1'b0, 1'b1, 8'd5, "t6_run_open");
        step(1'b0, 1'b1, 8'd5, "t6_run_held");
        step(1'b1, 1'b1, 8'd0, "midrun_reset");
        step(1'b0, 1'b1, 8'd1, "post_reset_run");
        step(1'b0, 1'b1, 8'd1, "post_reset_hold");
        step(1'b0, 1'b0, 8'd1, "post_reset_zero");

        stim_done = 1'b1;
    end

    initial begin
        int guard;
        wait (stim_done);
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
